// File: rtl/mm_seq_ctrl_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
// Provides the state enum and a width helper that never returns zero.
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    AWAIT,
    MAC,
    STORE,
    CWAIT,
    FIN,
    ERR
  } state_e;

  // A dimension of 1 still needs a 1-bit index so the ports stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_seq_ctrl_if.sv
// Sequencer <-> datapath bus: PIPO load strobes, addresses, MAC controls and done returns.
// The sequencer uses the master modport; the datapath side uses the slave modport.
interface mm_seq_ctrl_if #(
  parameter int M = 2,
  parameter int K = 2,
  parameter int N = 2
);

  localparam int AW = mm_pkg::idx_w(M * K);
  localparam int BW = mm_pkg::idx_w(K * N);
  localparam int CW = mm_pkg::idx_w(M * N);

  logic          ld_a;
  logic          ld_b;
  logic [AW-1:0] a_addr;
  logic [BW-1:0] b_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          st_c;
  logic [CW-1:0] c_addr;
  logic          a_done;
  logic          b_done;
  logic          c_done;

  modport master (
    output ld_a, ld_b, a_addr, b_addr, mac_en, mac_clr, st_c, c_addr,
    input  a_done, b_done, c_done
  );

  modport slave (
    input  ld_a, ld_b, a_addr, b_addr, mac_en, mac_clr, st_c, c_addr,
    output a_done, b_done, c_done
  );

endinterface

// File: rtl/mm_seq_ctrl_idx_counter.sv
// Nested k (inner), j (column), i (row) index counter for the multiply sequencer.
// k wraps on its own; j and i advance together once a C element has been stored.
module mm_idx_counter
  import mm_pkg::*;
#(
  parameter int M  = 2,
  parameter int K  = 2,
  parameter int N  = 2,
  parameter int IW = idx_w(M),
  parameter int JW = idx_w(N),
  parameter int KW = idx_w(K)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc_k,
  input  logic          inc_ij,
  output logic [IW-1:0] i_q,
  output logic [JW-1:0] j_q,
  output logic [KW-1:0] k_q,
  output logic          last_k,
  output logic          last_elem
);

  logic [IW-1:0] i_d;
  logic [JW-1:0] j_d;
  logic [KW-1:0] k_d;
  logic          last_i;
  logic          last_j;

  assign last_k    = (k_q == KW'(K - 1));
  assign last_j    = (j_q == JW'(N - 1));
  assign last_i    = (i_q == IW'(M - 1));
  assign last_elem = last_i && last_j;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else begin
      if (inc_k) begin
        k_d = last_k ? '0 : k_q + 1'b1;
      end
      if (inc_ij) begin
        if (last_j) begin
          j_d = '0;
          i_d = last_i ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/mm_seq_ctrl.sv
// Sequencer for one matrix multiply C = A x B: drives the A/B/C PIPOs and the MAC unit.
// All outputs decode from registered state, indices and held addresses only.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int M       = 2,
  parameter int K       = 2,
  parameter int N       = 2,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  mm_seq_ctrl_if.master dp,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int IW = idx_w(M);
  localparam int JW = idx_w(N);
  localparam int KW = idx_w(K);
  localparam int AW = idx_w(M * K);
  localparam int BW = idx_w(K * N);
  localparam int CW = idx_w(M * N);
  localparam int TW = idx_w(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [TW-1:0] wait_q, wait_d, wait_inc;
  logic          flag_a_q, flag_a_d, flag_b_q, flag_b_d;
  logic          a_seen, b_seen;
  logic [AW-1:0] a_hold_q, a_hold_d, a_calc;
  logic [BW-1:0] b_hold_q, b_hold_d, b_calc;
  logic [CW-1:0] c_hold_q, c_hold_d, c_calc;
  logic [IW-1:0] i_q;
  logic [JW-1:0] j_q;
  logic [KW-1:0] k_q;
  logic          idx_clr, inc_k, inc_ij, last_k, last_elem;

  mm_idx_counter #(
    .M (M),
    .K (K),
    .N (N)
  ) u_idx (
    .clk       (clk),
    .reset     (reset),
    .clr       (idx_clr),
    .inc_k     (inc_k),
    .inc_ij    (inc_ij),
    .i_q       (i_q),
    .j_q       (j_q),
    .k_q       (k_q),
    .last_k    (last_k),
    .last_elem (last_elem)
  );

  assign a_calc   = AW'(int'(i_q) * K + int'(k_q));
  assign b_calc   = BW'(int'(k_q) * N + int'(j_q));
  assign c_calc   = CW'(int'(i_q) * N + int'(j_q));
  assign wait_inc = wait_q + 1'b1;
  assign a_seen   = flag_a_q | dp.a_done;
  assign b_seen   = flag_b_q | dp.b_done;

  // A done seen on the cycle the wait count reaches TIMEOUT still wins over ERR.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    a_hold_d = a_hold_q;
    b_hold_d = b_hold_q;
    c_hold_d = c_hold_q;
    idx_clr  = 1'b0;
    inc_k    = 1'b0;
    inc_ij   = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d = LOAD;
          idx_clr = 1'b1;
        end
      end
      LOAD: begin
        state_d  = AWAIT;
        wait_d   = '0;
        flag_a_d = 1'b0;
        flag_b_d = 1'b0;
        a_hold_d = a_calc;
        b_hold_d = b_calc;
      end
      AWAIT: begin
        flag_a_d = a_seen;
        flag_b_d = b_seen;
        if (a_seen && b_seen) begin
          state_d = MAC;
        end else if (wait_inc == TW'(TIMEOUT)) begin
          state_d = ERR;
        end else begin
          wait_d = wait_inc;
        end
      end
      MAC: begin
        flag_a_d = 1'b0;
        flag_b_d = 1'b0;
        inc_k    = 1'b1;
        state_d  = last_k ? STORE : LOAD;
      end
      STORE: begin
        state_d  = CWAIT;
        wait_d   = '0;
        c_hold_d = c_calc;
      end
      CWAIT: begin
        if (dp.c_done) begin
          inc_ij  = 1'b1;
          state_d = last_elem ? FIN : LOAD;
        end else if (wait_inc == TW'(TIMEOUT)) begin
          state_d = ERR;
        end else begin
          wait_d = wait_inc;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
      a_hold_q <= '0;
      b_hold_q <= '0;
      c_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
      a_hold_q <= a_hold_d;
      b_hold_q <= b_hold_d;
      c_hold_q <= c_hold_d;
    end
  end

  // Addresses show the live index during the strobe and the captured copy afterwards.
  assign dp.a_addr  = (state_q == LOAD)  ? a_calc : a_hold_q;
  assign dp.b_addr  = (state_q == LOAD)  ? b_calc : b_hold_q;
  assign dp.c_addr  = (state_q == STORE) ? c_calc : c_hold_q;
  assign dp.ld_a    = (state_q == LOAD);
  assign dp.ld_b    = (state_q == LOAD);
  assign dp.mac_en  = (state_q == MAC);
  assign dp.mac_clr = (state_q == MAC) && (k_q == '0);
  assign dp.st_c    = (state_q == STORE);
  assign done       = (state_q == FIN);
  assign err        = (state_q == ERR);
  assign busy       = (state_q != IDLE) && (state_q != ERR);

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl: a 2x2x2 instance and a 3x1x2 instance driven by
// a small PIPO responder that returns each done a programmable number of cycles after its strobe.
module tb_mm_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start1, start2;
  logic busy1, done1, err1;
  logic busy2, done2, err2;

  mm_seq_ctrl_if #(.M(2), .K(2), .N(2)) bus1 ();
  mm_seq_ctrl_if #(.M(3), .K(1), .N(2)) bus2 ();

  mm_seq_ctrl #(.M(2), .K(2), .N(2), .TIMEOUT(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .dp    (bus1),
    .busy  (busy1),
    .done  (done1),
    .err   (err1)
  );

  mm_seq_ctrl #(.M(3), .K(1), .N(2), .TIMEOUT(16)) dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .dp    (bus2),
    .busy  (busy2),
    .done  (done2),
    .err   (err2)
  );

  int checks = 0;
  int errors = 0;

  bit   sel;
  int   cyc;
  int   a_dly, b_dly, c_dly, c_block;
  int   a_tmr, b_tmr, c_tmr;
  logic o_lda, o_ldb, o_stc, o_mac, o_clr, o_busy, o_done, o_err;
  int   o_aa, o_ba, o_ca;
  int   n_lda, n_ldb, n_stc, n_mac, n_clr, n_busy, n_done;
  int   done_cyc, err_cyc, last_stc_cyc;
  int   a_seq[$], b_seq[$], c_seq[$], clr_seq[$];

  task automatic sample();
    if (!sel) begin
      o_lda = bus1.ld_a; o_ldb = bus1.ld_b; o_stc = bus1.st_c;
      o_mac = bus1.mac_en; o_clr = bus1.mac_clr;
      o_aa = int'(bus1.a_addr); o_ba = int'(bus1.b_addr); o_ca = int'(bus1.c_addr);
      o_busy = busy1; o_done = done1; o_err = err1;
    end else begin
      o_lda = bus2.ld_a; o_ldb = bus2.ld_b; o_stc = bus2.st_c;
      o_mac = bus2.mac_en; o_clr = bus2.mac_clr;
      o_aa = int'(bus2.a_addr); o_ba = int'(bus2.b_addr); o_ca = int'(bus2.c_addr);
      o_busy = busy2; o_done = done2; o_err = err2;
    end
  endtask

  task automatic zero_dones();
    bus1.a_done = 1'b0; bus1.b_done = 1'b0; bus1.c_done = 1'b0;
    bus2.a_done = 1'b0; bus2.b_done = 1'b0; bus2.c_done = 1'b0;
  endtask

  task automatic clear_log();
    cyc = 0;
    a_tmr = 0; b_tmr = 0; c_tmr = 0;
    n_lda = 0; n_ldb = 0; n_stc = 0; n_mac = 0; n_clr = 0; n_busy = 0; n_done = 0;
    done_cyc = -1; err_cyc = -1; last_stc_cyc = -1;
    o_done = 1'b0; o_err = 1'b0;
    a_seq.delete(); b_seq.delete(); c_seq.delete(); clr_seq.delete();
    zero_dones();
  endtask

  // One clock: sample the selected DUT after the edge, then drive the PIPO dones for the next cycle.
  task automatic tick();
    logic ad, bd, cd;
    @(posedge clk);
    #1;
    cyc++;
    sample();
    ad = (a_tmr == 1); if (a_tmr > 0) a_tmr--; if (o_lda) a_tmr = a_dly;
    bd = (b_tmr == 1); if (b_tmr > 0) b_tmr--; if (o_ldb) b_tmr = b_dly;
    cd = (c_tmr == 1); if (c_tmr > 0) c_tmr--; if (o_stc && o_ca != c_block) c_tmr = c_dly;
    if (!sel) begin
      bus1.a_done = ad; bus1.b_done = bd; bus1.c_done = cd;
    end else begin
      bus2.a_done = ad; bus2.b_done = bd; bus2.c_done = cd;
    end
    if (o_lda) begin n_lda++; a_seq.push_back(o_aa); end
    if (o_ldb) begin n_ldb++; b_seq.push_back(o_ba); end
    if (o_stc) begin n_stc++; c_seq.push_back(o_ca); last_stc_cyc = cyc; end
    if (o_mac) begin n_mac++; clr_seq.push_back(int'(o_clr)); if (o_clr) n_clr++; end
    if (o_busy) n_busy++;
    if (o_done) begin n_done++; done_cyc = cyc; end
    if (o_err && err_cyc < 0) err_cyc = cyc;
  endtask

  task automatic do_start();
    if (!sel) start1 = 1'b1; else start2 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic run_to_end(input int budget);
    while (!(o_done || o_err) && cyc < budget) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; start1 = 1'b0; start2 = 1'b0; sel = 1'b0;
    a_dly = 1; b_dly = 1; c_dly = 1; c_block = -1;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    sample();
    checks++;
    if ({o_busy, o_done, o_err, o_lda, o_ldb, o_stc, o_mac, o_clr} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b%b%b%b%b%b%b%b expected 00000000", o_busy, o_done, o_err, o_lda, o_ldb, o_stc, o_mac, o_clr);
    end
    checks++;
    if (o_aa !== 0 || o_ba !== 0 || o_ca !== 0) begin
      errors++;
      $display("[TB] FAIL reset_addr got a=%0d b=%0d c=%0d expected 0/0/0", o_aa, o_ba, o_ca);
    end
    sel = 1'b1;
    sample();
    checks++;
    if ({o_busy, o_done, o_err, o_lda, o_stc, o_mac} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_dut2 got %b%b%b%b%b%b expected 000000", o_busy, o_done, o_err, o_lda, o_stc, o_mac);
    end
    sel = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_busy, o_done, o_err, o_lda, o_stc} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got %b%b%b%b%b expected 00000", o_busy, o_done, o_err, o_lda, o_stc);
    end
  endtask

  task automatic test_basic();
    int exp_a[8]   = '{0, 1, 0, 1, 2, 3, 2, 3};
    int exp_b[8]   = '{0, 2, 1, 3, 0, 2, 1, 3};
    int exp_c[4]   = '{0, 1, 2, 3};
    int exp_clr[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    sel = 1'b0; a_dly = 1; b_dly = 1; c_dly = 1; c_block = -1;
    clear_log();
    do_start();
    run_to_end(100);
    checks++; if (done_cyc !== 33) begin errors++; $display("[TB] FAIL basic_done_cycle got %0d expected 33", done_cyc); end
    checks++; if (n_busy !== 33) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d expected 33", n_busy); end
    checks++; if (n_lda !== 8 || n_ldb !== 8) begin errors++; $display("[TB] FAIL basic_loads got a=%0d b=%0d expected 8/8", n_lda, n_ldb); end
    checks++; if (n_stc !== 4) begin errors++; $display("[TB] FAIL basic_stores got %0d expected 4", n_stc); end
    for (int i = 0; i < 8 && i < a_seq.size() && i < b_seq.size(); i++) begin
      checks++;
      if (a_seq[i] !== exp_a[i] || b_seq[i] !== exp_b[i]) begin
        errors++;
        $display("[TB] FAIL basic_ab_addr[%0d] got a=%0d b=%0d expected a=%0d b=%0d", i, a_seq[i], b_seq[i], exp_a[i], exp_b[i]);
      end
    end
    for (int i = 0; i < 4 && i < c_seq.size(); i++) begin
      checks++;
      if (c_seq[i] !== exp_c[i]) begin errors++; $display("[TB] FAIL basic_c_addr[%0d] got %0d expected %0d", i, c_seq[i], exp_c[i]); end
    end
    for (int i = 0; i < 8 && i < clr_seq.size(); i++) begin
      checks++;
      if (clr_seq[i] !== exp_clr[i]) begin errors++; $display("[TB] FAIL basic_mac_clr[%0d] got %0d expected %0d", i, clr_seq[i], exp_clr[i]); end
    end
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_back_idle got busy=%b done=%b err=%b expected 0/0/0", o_busy, o_done, o_err);
    end
  endtask

  task automatic test_skew();
    sel = 1'b0; a_dly = 1; b_dly = 5; c_dly = 1; c_block = -1;
    clear_log();
    do_start();
    run_to_end(200);
    checks++; if (done_cyc !== 65) begin errors++; $display("[TB] FAIL skew_done_cycle got %0d expected 65", done_cyc); end
    checks++; if (n_mac !== 8) begin errors++; $display("[TB] FAIL skew_mac_count got %0d expected 8", n_mac); end
    checks++; if (n_clr !== 4) begin errors++; $display("[TB] FAIL skew_clr_count got %0d expected 4", n_clr); end
    checks++; if (n_busy !== 65) begin errors++; $display("[TB] FAIL skew_busy_cycles got %0d expected 65", n_busy); end
    tick();
  endtask

  task automatic test_timeout();
    sel = 1'b0; a_dly = 1; b_dly = 1; c_dly = 1; c_block = 2;
    clear_log();
    do_start();
    run_to_end(100);
    checks++; if (err_cyc !== 40) begin errors++; $display("[TB] FAIL timeout_err_cycle got %0d expected 40", err_cyc); end
    checks++; if (err_cyc - last_stc_cyc !== 17) begin errors++; $display("[TB] FAIL timeout_cwait_len got %0d expected 17", err_cyc - last_stc_cyc); end
    checks++; if (o_busy !== 1'b0 || n_done !== 0) begin errors++; $display("[TB] FAIL timeout_state got busy=%b dones=%0d expected 0/0", o_busy, n_done); end
    repeat (3) tick();
    checks++;
    if (o_err !== 1'b1 || o_lda !== 1'b0 || o_stc !== 1'b0 || o_mac !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_sticky got err=%b ld=%b st=%b mac=%b expected 1/0/0/0", o_err, o_lda, o_stc, o_mac);
    end
    c_block = -1;
    clear_log();
    do_start();
    checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b1 || o_lda !== 1'b1 || o_aa !== 0) begin
      errors++;
      $display("[TB] FAIL restart_first got err=%b busy=%b ld=%b a=%0d expected 0/1/1/0", o_err, o_busy, o_lda, o_aa);
    end
    run_to_end(100);
    checks++; if (done_cyc !== 33) begin errors++; $display("[TB] FAIL restart_done_cycle got %0d expected 33", done_cyc); end
    checks++;
    if (c_seq.size() !== 4 || c_seq[0] !== 0 || c_seq[3] !== 3) begin
      errors++;
      $display("[TB] FAIL restart_c_addr got n=%0d first=%0d expected n=4 first=0 last=3", c_seq.size(), (c_seq.size() > 0) ? c_seq[0] : -1);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    sel = 1'b0; a_dly = 1; b_dly = 1; c_dly = 1; c_block = -1;
    clear_log();
    do_start();
    while (!o_done && cyc < 100) begin
      tick();
      start1 = (cyc == 4) || (cyc == 20) || o_done;
    end
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    checks++; if (n_done !== 1) begin errors++; $display("[TB] FAIL ignore_done_pulses got %0d expected 1", n_done); end
    checks++; if (done_cyc !== 33) begin errors++; $display("[TB] FAIL ignore_done_cycle got %0d expected 33", done_cyc); end
    checks++; if (n_busy !== 33 || o_busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_busy got cycles=%0d busy=%b expected 33/0", n_busy, o_busy); end
    checks++; if (n_lda !== 8) begin errors++; $display("[TB] FAIL ignore_loads got %0d expected 8", n_lda); end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; a_dly = 1; b_dly = 1; c_dly = 1; c_block = -1;
    clear_log();
    do_start();
    while (!(o_lda && o_aa == 3) && cyc < 100) tick();
    checks++; if (cyc !== 20) begin errors++; $display("[TB] FAIL midreset_load_cycle got %0d expected 20", cyc); end
    tick();
    reset = 1'b0;
    #1;
    sample();
    checks++;
    if ({o_busy, o_done, o_err, o_lda, o_ldb, o_stc, o_mac, o_clr} !== 8'b0 || o_aa !== 0 || o_ba !== 0 || o_ca !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs got ctrl=%b%b%b%b a=%0d b=%0d c=%0d expected all 0", o_busy, o_lda, o_stc, o_mac, o_aa, o_ba, o_ca);
    end
    zero_dones();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    clear_log();
    do_start();
    checks++; if (o_lda !== 1'b1 || o_aa !== 0 || o_ba !== 0) begin errors++; $display("[TB] FAIL midreset_restart got ld=%b a=%0d b=%0d expected 1/0/0", o_lda, o_aa, o_ba); end
    run_to_end(100);
    checks++; if (done_cyc !== 33 || n_stc !== 4) begin errors++; $display("[TB] FAIL midreset_rerun got done=%0d stores=%0d expected 33/4", done_cyc, n_stc); end
    tick();
  endtask

  task automatic test_shape();
    int exp_a[6] = '{0, 0, 1, 1, 2, 2};
    int exp_b[6] = '{0, 1, 0, 1, 0, 1};
    sel = 1'b1; a_dly = 1; b_dly = 1; c_dly = 1; c_block = -1;
    clear_log();
    do_start();
    run_to_end(100);
    checks++; if (done_cyc !== 31) begin errors++; $display("[TB] FAIL shape_done_cycle got %0d expected 31", done_cyc); end
    checks++; if (n_mac !== 6 || n_clr !== 6) begin errors++; $display("[TB] FAIL shape_mac_clr got mac=%0d clr=%0d expected 6/6", n_mac, n_clr); end
    checks++; if (n_stc !== 6) begin errors++; $display("[TB] FAIL shape_stores got %0d expected 6", n_stc); end
    for (int i = 0; i < 6 && i < c_seq.size() && i < a_seq.size() && i < b_seq.size(); i++) begin
      checks++;
      if (c_seq[i] !== i || a_seq[i] !== exp_a[i] || b_seq[i] !== exp_b[i]) begin
        errors++;
        $display("[TB] FAIL shape_addr[%0d] got a=%0d b=%0d c=%0d expected a=%0d b=%0d c=%0d", i, a_seq[i], b_seq[i], c_seq[i], exp_a[i], exp_b[i], i);
      end
    end
    tick();
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    test_shape();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
